// File: rtl/tilemap_pixel_shifter_pkg.sv
// Shared constants and payload types for the tilemap pixel shifter.
// Attribute bit positions, pixel/tile geometry and the captured tile-line record.
package tilemap_pkg;

  localparam int unsigned ATTR_XFLIP   = 7;
  localparam int unsigned ATTR_PRIO    = 6;
  localparam int unsigned ATTR_PAL_MSB = 5;

  localparam int unsigned PIX_W    = 4;
  localparam int unsigned TILE_PIX = 8;
  localparam int unsigned LINE_W   = PIX_W * TILE_PIX;
  localparam int unsigned ATTR_W   = 8;

  // One character line plus its tile attribute, as captured from the fetch bus.
  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic [ATTR_W-1:0] attr;
  } tile_line_t;

endpackage

// File: rtl/tilemap_pixel_shifter_if.sv
// Fetch/shift bus between the tilemap generator and the pixel shifter.
// master = generator side, slave = shifter side.
interface tilemap_pixel_shifter_if #(
  parameter int unsigned PAL_BITS = 6
);
  import tilemap_pkg::*;

  logic                      i_EMU_CLK6MPCEN_n;
  logic                      i_HFLIP;
  logic                      i_BLANK_n;
  logic                      i_SHIFTA1;
  logic                      i_SHIFTA2;
  logic                      i_SHIFTB;
  logic [LINE_W-1:0]         i_CHARDATA;
  logic [ATTR_W-1:0]         i_TILEATTR;
  logic [PAL_BITS+PIX_W-1:0] o_COLOR;
  logic                      o_LAYER;
  logic                      o_OPAQUE;

  modport master (
    output i_EMU_CLK6MPCEN_n, i_HFLIP, i_BLANK_n,
    output i_SHIFTA1, i_SHIFTA2, i_SHIFTB, i_CHARDATA, i_TILEATTR,
    input  o_COLOR, o_LAYER, o_OPAQUE
  );

  modport slave (
    input  i_EMU_CLK6MPCEN_n, i_HFLIP, i_BLANK_n,
    input  i_SHIFTA1, i_SHIFTA2, i_SHIFTB, i_CHARDATA, i_TILEATTR,
    output o_COLOR, o_LAYER, o_OPAQUE
  );

endinterface

// File: rtl/tilemap_pixel_shifter_tile_line_shifter.sv
// One layer's 8-pixel line shifter: loads a tile line, then emits one 4-bit pixel per ce.
// Shift direction is frozen at load so a mid-tile HFLIP change waits for the next tile.
module tile_line_shifter
  import tilemap_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              load,
  input  logic              hflip,
  input  tile_line_t        load_line,
  output logic [PIX_W-1:0]  head_c,
  output logic [ATTR_W-1:0] attr
);

  logic [LINE_W-1:0] data;
  logic              dir;

  // Load replaces the shift; zero fill makes an unreloaded line go transparent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      attr <= '0;
      dir  <= 1'b0;
    end else if (ce) begin
      if (load) begin
        data <= load_line.data;
        attr <= load_line.attr;
        dir  <= load_line.attr[ATTR_XFLIP] ^ hflip;
      end else if (dir) begin
        data <= data >> PIX_W;
      end else begin
        data <= data << PIX_W;
      end
    end
  end

  assign head_c = dir ? data[PIX_W-1:0] : data[LINE_W-1 -: PIX_W];

endmodule

// File: rtl/tilemap_pixel_shifter.sv
// Tilemap A/B pixel serialiser with A staging register and A/B priority mux.
// Produces a registered {palette, pixel} colour index per 6 MHz pixel enable.
module tilemap_pixel_shifter
  import tilemap_pkg::*;
#(
  parameter int unsigned PAL_BITS = 6
) (
  input  logic                    i_EMU_MCLK,
  input  logic                    i_RST,
  tilemap_pixel_shifter_if.slave  bus
);

  localparam int unsigned COLOR_W = PAL_BITS + PIX_W;

  logic              ce;
  tile_line_t        bus_line;
  tile_line_t        stag_a;
  logic [PIX_W-1:0]  head_a;
  logic [PIX_W-1:0]  head_b;
  logic [ATTR_W-1:0] attr_a;
  logic [ATTR_W-1:0] attr_b;
  logic              op_a;
  logic              op_b;
  logic [COLOR_W-1:0] color_d;
  logic               layer_d;
  logic               opaque_d;

  assign ce       = ~bus.i_EMU_CLK6MPCEN_n;
  assign bus_line = '{data: bus.i_CHARDATA, attr: bus.i_TILEATTR};

  // A staging: the A shifter reads the pre-edge value, so A1+A2 together pass the old tile on.
  always_ff @(posedge i_EMU_MCLK or posedge i_RST) begin
    if (i_RST) begin
      stag_a <= '0;
    end else if (ce && !bus.i_SHIFTA1) begin
      stag_a <= bus_line;
    end
  end

  tile_line_shifter u_shift_a (
    .clk       (i_EMU_MCLK),
    .rst       (i_RST),
    .ce        (ce),
    .load      (~bus.i_SHIFTA2),
    .hflip     (bus.i_HFLIP),
    .load_line (stag_a),
    .head_c    (head_a),
    .attr      (attr_a)
  );

  tile_line_shifter u_shift_b (
    .clk       (i_EMU_MCLK),
    .rst       (i_RST),
    .ce        (ce),
    .load      (~bus.i_SHIFTB),
    .hflip     (bus.i_HFLIP),
    .load_line (bus_line),
    .head_c    (head_b),
    .attr      (attr_b)
  );

  assign op_a = |head_a;
  assign op_b = |head_b;

  // B takes the pixel when opaque and either A is clear or B carries priority.
  always_comb begin
    color_d  = '0;
    layer_d  = 1'b0;
    opaque_d = 1'b0;
    if (bus.i_BLANK_n) begin
      if (op_b && (!op_a || attr_b[ATTR_PRIO])) begin
        color_d  = {PAL_BITS'(attr_b[ATTR_PAL_MSB:0]), head_b};
        layer_d  = 1'b1;
        opaque_d = 1'b1;
      end else if (op_a) begin
        color_d  = {PAL_BITS'(attr_a[ATTR_PAL_MSB:0]), head_a};
        layer_d  = 1'b0;
        opaque_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_EMU_MCLK or posedge i_RST) begin
    if (i_RST) begin
      bus.o_COLOR  <= '0;
      bus.o_LAYER  <= 1'b0;
      bus.o_OPAQUE <= 1'b0;
    end else if (ce) begin
      bus.o_COLOR  <= color_d;
      bus.o_LAYER  <= layer_d;
      bus.o_OPAQUE <= opaque_d;
    end
  end

endmodule

// File: tb/tb_tilemap_pixel_shifter.sv
// Directed bench for tilemap_pixel_shifter: serialise, flip, A staging, priority, blank, reset.
module tb_tilemap_pixel_shifter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  tilemap_pixel_shifter_if #(.PAL_BITS(6)) bus ();

  tilemap_pixel_shifter #(.PAL_BITS(6)) dut (
    .i_EMU_MCLK (clk),
    .i_RST      (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Expected output packed as {color[9:0], layer, opaque}.
  function automatic logic [11:0] px(input logic [9:0] color, input logic layer);
    return {color, layer, 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [11:0] exp);
    logic [11:0] got;
    got = {bus.o_COLOR, bus.o_LAYER, bus.o_OPAQUE};
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
  endtask

  // One master clock; strobes are single-cycle and released after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.i_SHIFTA1 = 1'b1;
    bus.i_SHIFTA2 = 1'b1;
    bus.i_SHIFTB  = 1'b1;
  endtask

  task automatic drain();
    repeat (9) tick();
  endtask

  task automatic load_b(input logic [31:0] d, input logic [7:0] a);
    bus.i_SHIFTB   = 1'b0;
    bus.i_CHARDATA = d;
    bus.i_TILEATTR = a;
    tick();
  endtask

  initial begin
    bus.i_EMU_CLK6MPCEN_n = 1'b0;
    bus.i_HFLIP    = 1'b0;
    bus.i_BLANK_n  = 1'b1;
    bus.i_SHIFTA1  = 1'b1;
    bus.i_SHIFTA2  = 1'b1;
    bus.i_SHIFTB   = 1'b1;
    bus.i_CHARDATA = '0;
    bus.i_TILEATTR = '0;

    tick();
    tick();
    chk("reset_state", 12'h000);
    rst = 1'b0;
    tick();
    chk("post_reset_idle", 12'h000);

    // Basic serialise, no flip
    load_b(32'h1234_5678, 8'h05);
    chk("basic_load_cycle", 12'h000);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("basic_px%0d", k), px(10'(16'h051 + k), 1'b1));
    end
    tick();
    chk("basic_underrun", 12'h000);

    // Tile X-flip
    load_b(32'h1234_5678, 8'h85);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("xflip_px%0d", k), px(10'(16'h058 - k), 1'b1));
    end
    drain();

    // X-flip and HFLIP cancel; HFLIP change mid-tile ignored
    bus.i_HFLIP = 1'b1;
    load_b(32'h1234_5678, 8'h85);
    bus.i_HFLIP = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("cancel_px%0d", k), px(10'(16'h051 + k), 1'b1));
    end
    drain();

    // HFLIP alone reverses at the next load
    bus.i_HFLIP = 1'b1;
    load_b(32'h1234_5678, 8'h05);
    bus.i_HFLIP = 1'b0;
    tick();
    chk("hflip_px0", px(10'h058, 1'b1));
    drain();

    // Pixel enable held off freezes state and outputs
    load_b(32'h1234_5678, 8'h05);
    tick();
    chk("ce_px0", px(10'h051, 1'b1));
    bus.i_EMU_CLK6MPCEN_n = 1'b1;
    tick();
    tick();
    chk("ce_hold", px(10'h051, 1'b1));
    bus.i_EMU_CLK6MPCEN_n = 1'b0;
    tick();
    chk("ce_resume_px1", px(10'h052, 1'b1));
    drain();

    // A two-stage path
    bus.i_SHIFTA1  = 1'b0;
    bus.i_CHARDATA = 32'hAAAA_AAAA;
    bus.i_TILEATTR = 8'h01;
    tick();
    tick();
    tick();
    chk("a_staged_only", 12'h000);
    bus.i_SHIFTA2 = 1'b0;
    tick();
    chk("a_xfer_cycle", 12'h000);
    tick();
    chk("a_px0", px(10'h01A, 1'b0));
    drain();

    // Simultaneous A1+A2: shifter takes old staging
    bus.i_SHIFTA1  = 1'b0;
    bus.i_SHIFTA2  = 1'b0;
    bus.i_CHARDATA = 32'h1111_1111;
    bus.i_TILEATTR = 8'h03;
    tick();
    tick();
    chk("a1a2_old_first", px(10'h01A, 1'b0));
    drain();
    bus.i_SHIFTA2 = 1'b0;
    tick();
    tick();
    chk("a1a2_new_next", px(10'h031, 1'b0));
    drain();

    // Priority: A opaque, B opaque without priority
    bus.i_SHIFTA1  = 1'b0;
    bus.i_CHARDATA = 32'hFFFF_FFFF;
    bus.i_TILEATTR = 8'h02;
    tick();
    bus.i_SHIFTA2  = 1'b0;
    bus.i_SHIFTB   = 1'b0;
    bus.i_CHARDATA = 32'h3333_3333;
    bus.i_TILEATTR = 8'h04;
    tick();
    tick();
    chk("prio_a_wins", px(10'h02F, 1'b0));
    load_b(32'h3333_3333, 8'h44);
    chk("prio_reload_cycle", px(10'h02F, 1'b0));
    tick();
    chk("prio_b_wins", px(10'h043, 1'b1));
    drain();

    // A transparent: B wins without priority
    bus.i_SHIFTA1  = 1'b0;
    bus.i_CHARDATA = 32'h0000_0000;
    bus.i_TILEATTR = 8'h02;
    tick();
    bus.i_SHIFTA2  = 1'b0;
    bus.i_SHIFTB   = 1'b0;
    bus.i_CHARDATA = 32'h3333_3333;
    bus.i_TILEATTR = 8'h04;
    tick();
    tick();
    chk("prio_a_clear", px(10'h043, 1'b1));
    drain();

    // Blanking keeps the shifter running
    load_b(32'h1234_5678, 8'h05);
    tick();
    chk("blank_px0", px(10'h051, 1'b1));
    bus.i_BLANK_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("blank_%0d", k), 12'h000);
    end
    bus.i_BLANK_n = 1'b1;
    tick();
    chk("blank_end_px4", px(10'h055, 1'b1));
    drain();

    // Reset mid-line clears asynchronously
    load_b(32'h1234_5678, 8'h05);
    tick();
    chk("rst_pre", px(10'h051, 1'b1));
    rst = 1'b1;
    #1;
    chk("rst_async", 12'h000);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_release_idle", 12'h000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tilemap_pixel_shifter.md
Name: tilemap_pixel_shifter

Overview:
- Consumer end of the tilemap generator's fetch/shift interface.
- Captures per-tile character line data (8 px × 4 bpp) and tile attributes for tilemaps A and B when the generator's active-low shift strobes fire.
- Serialises one pixel per 6 MHz pixel enable per layer, honouring per-tile X-flip and global HFLIP, then resolves A/B priority into one colour index for the palette stage.

Parameters:
PAL_BITS, 6, palette-select width taken from tile attribute [5:0]; output colour width = PAL_BITS+4

Ports:
i_EMU_MCLK  in  1  master clock; all state on posedge
i_RST  in  1  asynchronous, active-high reset
i_EMU_CLK6MPCEN_n  in  1  active-low pixel clock enable; state advances only when low
i_HFLIP  in  1  global horizontal flip (CPU flip register)
i_BLANK_n  in  1  low = blanking; outputs forced to zero
i_SHIFTA1  in  1  active-low: capture A tile into A staging register
i_SHIFTA2  in  1  active-low: transfer A staging into A shifter
i_SHIFTB  in  1  active-low: capture B tile directly into B shifter
i_CHARDATA  in  32  CHARRAM line data; pixel k = bits [31-4k:28-4k]
i_TILEATTR  in  8  [7]=tile X-flip, [6]=priority, [5:0]=palette
o_COLOR  out  PAL_BITS+4  {palette, pixel}
o_LAYER  out  1  0=A won, 1=B won
o_OPAQUE  out  1  selected pixel non-zero

Behaviour:
- Reset: all staging/shifter/attribute registers and every output = 0; async assert, release synchronous to i_EMU_MCLK.
- No register changes on cycles with i_EMU_CLK6MPCEN_n=1.
- Per-layer shifter: 32-bit data, latched attr, direction bit dir = attr[7] ^ i_HFLIP, sampled at load.
- Shift rule: dir=0 → head = data[31:28], shift left 4, zero fill. dir=1 → head = data[3:0], shift right 4, zero fill.
- After 8 shifts without reload a layer is all-zero, i.e. transparent (underrun-safe).
- Load rule (on a ce with strobe low):
  - Load replaces the shift; it never combines with one.
  - SHIFTA1 → stagA <= {i_CHARDATA, i_TILEATTR}.
  - SHIFTA2 → shA <= stagA as it was before this edge.
  - SHIFTB → shB <= {i_CHARDATA, i_TILEATTR}.
- Simultaneous SHIFTA1 and SHIFTA2: A shifter gets the old staging value; staging gets the new bus value.
- Latency: strobe on ce n → pixel 0 on o_COLOR after ce n+1; pixel k after ce n+1+k.
- Output register, updated each ce from the current heads:
  - Let opA = headA≠0 and opB = headB≠0.
  - B wins if opB and (!opA or attrB[6]).
  - Otherwise A wins if opA.
  - Otherwise o_COLOR=0, o_LAYER=0, o_OPAQUE=0.
  - Winner drives o_COLOR={pal, head}, o_LAYER, o_OPAQUE=1.
- Blanking: i_BLANK_n=0 at ce → outputs 0. Shifters still shift/load, so the pipeline stays aligned.
- i_HFLIP change mid-tile: takes effect at that layer's next load only.

Decomposition:
- Package tilemap_pkg:
  - attribute bit positions ATTR_XFLIP=7, ATTR_PRIO=6, ATTR_PAL_MSB=5.
  - pixel width 4, pixels per tile 8.
- Sub-module tile_line_shifter: load/shift/head/attr/direction logic. Instantiated twice (A, B); the A staging register is kept in the top level.

Test Plan:
- Reset: assert i_RST mid-line with shifters loaded → all outputs 0 immediately; first strobe-free ce after release outputs 0.
- Basic serialise: SHIFTB=0 with data 32'h12345678, attr 8'h05, HFLIP=0, A empty → o_COLOR = 0x051…0x058 on ce n+1…n+8, o_LAYER=1, then 0x000 with o_OPAQUE=0.
- Flip: same load with attr 8'h85 → 0x058…0x051. With attr 8'h85 and HFLIP=1 → 0x051…0x058 (flips cancel).
- A two-stage path:
  - SHIFTA1 with 32'hAAAA_AAAA, attr 8'h01.
  - Three ce later, SHIFTA2 → 0x01A appears from ce+1 after SHIFTA2.
  - Same-cycle A1+A2 with a new bus value 32'h1111_1111 → old A data shifts first.
- Priority:
  - A=0xF px attr 8'h02, B=0x3 px attr 8'h04 → 0x02F, LAYER=0.
  - Change B attr to 8'h44 → 0x043, LAYER=1.
  - A px=0, B px=3 → B regardless of priority.
- Blanking: i_BLANK_n=0 for 3 ce during a B tile → outputs 0, then pixel 4 (not pixel 1) appears when blank ends.
